// File: rtl/supersample_sched.sv
// Supersample scheduler: round-robin arbitration of Cb/Cr 8x8 blocks into a shared
// supersampler, then serialization of the four upsampled quadrants downstream.
module supersample_sched #(
  parameter int unsigned DW = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cb_valid,
  output logic                    cb_ready,
  input  logic [7:0][7:0][DW-1:0] cb_block,
  input  logic                    cr_valid,
  output logic                    cr_ready,
  input  logic [7:0][7:0][DW-1:0] cr_block,
  output logic [1:0]              ss_ch,
  output logic                    ss_valid_in,
  output logic [7:0][7:0][DW-1:0] ss_block_in,
  input  logic [7:0][7:0][DW-1:0] ss_block_1_out,
  input  logic [7:0][7:0][DW-1:0] ss_block_2_out,
  input  logic [7:0][7:0][DW-1:0] ss_block_3_out,
  input  logic [7:0][7:0][DW-1:0] ss_block_4_out,
  input  logic [3:0]              ss_valid_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0][7:0][DW-1:0] out_block,
  output logic [1:0]              out_ch,
  output logic [1:0]              out_idx,
  output logic                    err,
  output logic [15:0]             blk_count
);

  localparam int unsigned NQ = 4;
  localparam logic [1:0] CH_IDLE = 2'b00;
  localparam logic [1:0] CH_CB   = 2'b01;
  localparam logic [1:0] CH_CR   = 2'b10;

  typedef logic [7:0][7:0][DW-1:0] blk_t;
  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;
  logic   last_cr;
  logic   grant_cb, grant_cr, grant, handshake;
  blk_t   quad_buf [NQ];

  assign grant     = grant_cb | grant_cr;
  assign handshake = out_valid & out_ready;

  // Grant decode and supersampler drive; the grant is combinational within the IDLE cycle.
  always_comb begin
    state_nxt   = state;
    grant_cb    = 1'b0;
    grant_cr    = 1'b0;
    cb_ready    = 1'b0;
    cr_ready    = 1'b0;
    ss_valid_in = 1'b0;
    ss_ch       = CH_IDLE;
    ss_block_in = '0;
    case (state)
      IDLE: begin
        if (!reset) begin
          // On a tie the channel not granted last wins.
          if (cb_valid && (!cr_valid || last_cr)) grant_cb = 1'b1;
          else if (cr_valid)                      grant_cr = 1'b1;
        end
      end
      EMIT: begin
        if (handshake && out_idx == 2'd3) state_nxt = IDLE;
      end
    endcase
    if (grant_cb) begin
      cb_ready    = 1'b1;
      ss_valid_in = 1'b1;
      ss_ch       = CH_CB;
      ss_block_in = cb_block;
      state_nxt   = EMIT;
    end
    if (grant_cr) begin
      cr_ready    = 1'b1;
      ss_valid_in = 1'b1;
      ss_ch       = CH_CR;
      ss_block_in = cr_block;
      state_nxt   = EMIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Quadrant capture, output serialization and status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NQ); i++) quad_buf[i] <= '0;
      out_valid <= 1'b0;
      out_block <= '0;
      out_ch    <= CH_IDLE;
      out_idx   <= 2'd0;
      err       <= 1'b0;
      blk_count <= 16'd0;
      last_cr   <= 1'b1;
    end else if (grant) begin
      quad_buf[0] <= ss_block_1_out;
      quad_buf[1] <= ss_block_2_out;
      quad_buf[2] <= ss_block_3_out;
      quad_buf[3] <= ss_block_4_out;
      out_block   <= ss_block_1_out;
      out_valid   <= 1'b1;
      out_ch      <= grant_cb ? CH_CB : CH_CR;
      out_idx     <= 2'd0;
      last_cr     <= grant_cr;
      if (ss_valid_out != 4'b1111) err <= 1'b1;
    end else if (handshake) begin
      out_idx   <= out_idx + 2'd1;
      out_block <= quad_buf[out_idx + 2'd1];
      if (out_idx == 2'd3) begin
        out_valid <= 1'b0;
        blk_count <= blk_count + 16'd1;
      end
    end
  end

endmodule
